// File: rtl/mp_pkg.sv
// Shared encodings for the multi-precision add/sub/compare engine.
package mp_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Sub and compare both compute A + ~B + 1; reserved mode 11 falls back to add.
  function automatic logic is_sub(input logic [1:0] mode);
    return (mode == MODE_SUB) || (mode == MODE_CMP);
  endfunction

endpackage

// File: rtl/mp_addsub_if.sv
// Request/result bundle between the operand datapath and mp_addsub.
interface mp_addsub_if #(
  parameter int OPERAND_WIDTH = 1024
);
  logic                     iStart;
  logic [1:0]               iMode;
  logic [OPERAND_WIDTH-1:0] iOpA;
  logic [OPERAND_WIDTH-1:0] iOpB;
  logic                     oReady;
  logic                     oBusy;
  logic [OPERAND_WIDTH-1:0] oRes;
  logic                     oCarry;
  logic                     oZero;
  logic                     oDone;

  modport master (
    output iStart, iMode, iOpA, iOpB,
    input  oReady, oBusy, oRes, oCarry, oZero, oDone
  );

  modport slave (
    input  iStart, iMode, iOpA, iOpB,
    output oReady, oBusy, oRes, oCarry, oZero, oDone
  );
endinterface

// File: rtl/mp_word_adder.sv
// Combinational single-word adder with carry in and carry out.
module mp_word_adder #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
endmodule

// File: rtl/mp_addsub.sv
// Word-serial multi-precision add/sub/compare, LSW first, with registered
// result and flags that only change on completion.
module mp_addsub
  import mp_pkg::*;
#(
  parameter int OPERAND_WIDTH = 1024,
  parameter int ADDER_WIDTH   = 256
) (
  input logic        iClk,
  input logic        iRstn,
  mp_addsub_if.slave bus
);
  localparam int N_ITERATIONS = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CNT_W        = $clog2(N_ITERATIONS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITERATIONS - 1);

  logic [1:0]               state_q, state_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPERAND_WIDTH-1:0] acc_q, acc_d;
  logic [OPERAND_WIDTH-1:0] res_q, res_d;
  logic [1:0]               mode_q, mode_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cin_q, cin_d;
  logic                     zacc_q, zacc_d;
  logic                     carry_q, carry_d;
  logic                     zero_q, zero_d;
  logic                     done_q, done_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic [ADDER_WIDTH-1:0] sum_s;
  logic                   cout_s;
  logic                   accept_s;

  mp_word_adder #(.WIDTH(ADDER_WIDTH)) u_word_adder (
    .a_i    (a_q[ADDER_WIDTH-1:0]),
    .b_i    (b_q[ADDER_WIDTH-1:0]),
    .cin_i  (cin_q),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  assign accept_s = bus.iStart & ready_q;

  // Next-state, datapath shift and completion-flag logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = S_RUN;
          a_d     = bus.iOpA;
          b_d     = is_sub(bus.iMode) ? ~bus.iOpB : bus.iOpB;
          mode_d  = bus.iMode;
          cin_d   = is_sub(bus.iMode);
          cnt_d   = {CNT_W{1'b0}};
          zacc_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d    = a_q >> ADDER_WIDTH;
        b_d    = b_q >> ADDER_WIDTH;
        // Each new word lands at the top so after N words the LSW sits at bit 0.
        acc_d  = (acc_q >> ADDER_WIDTH) |
                 (OPERAND_WIDTH'(sum_s) << (OPERAND_WIDTH - ADDER_WIDTH));
        cin_d  = cout_s;
        zacc_d = zacc_q | (|sum_s);
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (mode_q != MODE_CMP) begin
            res_d = acc_d;
          end else begin
            res_d = res_q;
          end
          carry_d = is_sub(mode_q) ? ~cout_s : cout_s;
          zero_d  = ~zacc_d;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= S_IDLE;
      a_q     <= {OPERAND_WIDTH{1'b0}};
      b_q     <= {OPERAND_WIDTH{1'b0}};
      acc_q   <= {OPERAND_WIDTH{1'b0}};
      res_q   <= {OPERAND_WIDTH{1'b0}};
      mode_q  <= 2'b00;
      cnt_q   <= {CNT_W{1'b0}};
      cin_q   <= 1'b0;
      zacc_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oRes   = res_q;
  assign bus.oCarry = carry_q;
  assign bus.oZero  = zero_q;
  assign bus.oDone  = done_q;
  assign bus.oReady = ready_q;
  assign bus.oBusy  = busy_q;

endmodule

// File: tb/tb_mp_addsub.sv
// Scoreboard bench for mp_addsub: a 16/4 instance and a 16/16 instance.
module tb_mp_addsub;
  import mp_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        carry;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q4[$];
  exp_t q16[$];

  mp_addsub_if #(.OPERAND_WIDTH(16)) bus4 ();
  mp_addsub_if #(.OPERAND_WIDTH(16)) bus16 ();

  mp_addsub #(.OPERAND_WIDTH(16), .ADDER_WIDTH(4)) dut4 (
    .iClk  (clk),
    .iRstn (rst_n),
    .bus   (bus4)
  );

  mp_addsub #(.OPERAND_WIDTH(16), .ADDER_WIDTH(16)) dut16 (
    .iClk  (clk),
    .iRstn (rst_n),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 4) ? bus4.oReady : bus16.oReady;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [1:0] mode,
                       input logic [15:0] a, input logic [15:0] b);
    if (sel == 4) begin
      bus4.iStart = st; bus4.iMode = mode; bus4.iOpA = a; bus4.iOpB = b;
    end else begin
      bus16.iStart = st; bus16.iMode = mode; bus16.iOpA = a; bus16.iOpB = b;
    end
  endtask

  // Waits for ready, lets the next edge accept, and queues the expected response.
  task automatic issue(input int sel, input logic [1:0] mode, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic ec,
                       input logic ez, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    drive(sel, 1'b1, mode, a, b);
    while (!rdy(sel) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    e.res = er; e.carry = ec; e.zero = ez;
    e.cyc = cyc + ((sel == 4) ? 4 : 1);
    if (sel == 4) q4.push_back(e); else q16.push_back(e);
    if (!hold) begin
      if (sel == 4) bus4.iStart = 1'b0; else bus16.iStart = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q4.size() + q16.size()), 32'd0);
  endtask

  task automatic chk_reset(input int sel);
    if (sel == 4) begin
      chk("rst4_res", 32'(bus4.oRes), 32'd0);
      chk("rst4_flags", {28'd0, bus4.oCarry, bus4.oZero, bus4.oDone, bus4.oBusy}, 32'd0);
      chk("rst4_ready", 32'(bus4.oReady), 32'd1);
    end else begin
      chk("rst16_res", 32'(bus16.oRes), 32'd0);
      chk("rst16_flags", {28'd0, bus16.oCarry, bus16.oZero, bus16.oDone, bus16.oBusy}, 32'd0);
      chk("rst16_ready", 32'(bus16.oReady), 32'd1);
    end
  endtask

  // Monitor for the 4-word instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus4.oDone) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("res4", 32'(bus4.oRes), 32'(e.res));
        chk("carry4", 32'(bus4.oCarry), 32'(e.carry));
        chk("zero4", 32'(bus4.oZero), 32'(e.zero));
        chk("done4_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Monitor for the single-word instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus16.oDone) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        chk("res16", 32'(bus16.oRes), 32'(e.res));
        chk("carry16", 32'(bus16.oCarry), 32'(e.carry));
        chk("zero16", 32'(bus16.oZero), 32'(e.zero));
        chk("done16_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    exp_t dropped;
    drive(4, 1'b0, MODE_ADD, 16'h0000, 16'h0000);
    drive(16, 1'b0, MODE_ADD, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk_reset(4);
    chk_reset(16);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add with carry-out and all-zero result.
    issue(4, MODE_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    // Subtraction with and without borrow.
    issue(4, MODE_SUB, 16'h1234, 16'h1235, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    issue(4, MODE_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
    // Compare leaves the previous result in place.
    issue(4, MODE_CMP, 16'hABCD, 16'hABCD, 16'h0002, 1'b0, 1'b1, 1'b0);
    issue(4, MODE_CMP, 16'h0001, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0);

    // A start pulse while busy must be ignored.
    issue(4, MODE_ADD, 16'h0100, 16'h0020, 16'h0120, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b1, MODE_ADD, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    bus4.iStart = 1'b0;

    // Start held through DONE: back-to-back acceptance, done pulses 5 cycles apart.
    issue(4, MODE_ADD, 16'h7000, 16'h9000, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(4, MODE_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Reset in the second RUN cycle aborts with no completion.
    issue(4, MODE_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
    dropped = q4.pop_back();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset(4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(4, MODE_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Single-word configuration and reserved mode.
    issue(16, MODE_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(16, 2'b11, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_addsub.md
# mp_addsub

Multi-cycle, multi-precision adder/subtractor/comparator that processes OPERAND_WIDTH-bit operands one ADDER_WIDTH-bit word per cycle, LSW first. It sits between the operand-holding datapath and the arithmetic consumers. It generalises the team's fixed add/sub engine in four ways:
- runtime mode select: add, subtract or compare
- ready/start handshake that accepts back-to-back operations
- stable registered result outputs
- carry/borrow and zero flags

## Interface
- OPERAND_WIDTH, 1024, operand and result width; must be an integer multiple of ADDER_WIDTH
- ADDER_WIDTH, 256, word width processed per cycle; 1 ≤ ADDER_WIDTH ≤ OPERAND_WIDTH
- N_ITERATIONS, derived localparam OPERAND_WIDTH/ADDER_WIDTH, not overridable
- iClk  in  1  clock, rising edge
- iRstn  in  1  reset, asynchronous assert, active-low; one clock, no other reset
- iStart  in  1  request; accepted on a rising edge where iStart=1 and oReady=1
- iMode  in  2  00 add, 01 sub, 10 cmp, 11 reserved (behaves as add)
- iOpA  in  OPERAND_WIDTH  operand A, sampled only at acceptance
- iOpB  in  OPERAND_WIDTH  operand B, sampled only at acceptance
- oReady  out  1  high in IDLE and DONE
- oBusy  out  1  high in RUN
- oRes  out  OPERAND_WIDTH  registered result
- oCarry  out  1  add: carry-out; sub/cmp: borrow (A<B unsigned)
- oZero  out  1  high when the full-width result is all zeros
- oDone  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on acceptance.
  - RUN→DONE after the N_ITERATIONS-th word.
  - DONE→RUN if iStart=1, else DONE→IDLE.
- Acceptance edge actions:
  - load iOpA into the A shift register
  - load iOpB into the B shift register; load ~iOpB if the mode is sub or cmp
  - latch iMode
  - set carry-in = 1 for sub/cmp, 0 otherwise
  - clear the word counter and the zero accumulator
- Each RUN cycle:
  - word adder computes A[ADDER_WIDTH-1:0] + B[ADDER_WIDTH-1:0] + cin
  - sum shifts into the MSB end of the internal result register
  - A and B shift right by ADDER_WIDTH
  - carry register takes the carry-out and feeds the next word's cin
  - zero accumulator ORs in |sum
  - counter increments
- On the RUN→DONE edge:
  - add/sub: oRes ← full internal result
  - cmp: oRes unchanged
  - all modes: oCarry ← carry-out for add, ~carry-out for sub/cmp; oZero ← ~accumulator; oDone ← 1
- Outputs hold until the next completion. No intermediate word is ever visible on oRes.
- iStart while oBusy=1 is ignored; iOpA, iOpB and iMode are not sampled.
- Arithmetic is unsigned, modulo 2^OPERAND_WIDTH. Signed overflow is not reported.

## Timing
- Reset values:
  - oRes 0, oCarry 0, oZero 0, oDone 0, oBusy 0, oReady 1
  - state IDLE, counter 0, all internal registers 0
- Reset asserted mid-RUN aborts the operation immediately. No oDone is produced. oReady=1 from reset release.
- Latency: acceptance at edge E gives oDone=1 and valid outputs in the cycle after edge E+N_ITERATIONS.
- Throughput: a start during DONE is accepted. Consecutive oDone pulses are then N_ITERATIONS+1 cycles apart.
- N_ITERATIONS=1: one RUN cycle, oDone after edge E+1.
- Counter width is $clog2(N_ITERATIONS)+1.

## Structure
- Shared package mp_pkg holds:
  - mode encodings: MODE_ADD, MODE_SUB, MODE_CMP
  - state encodings: S_IDLE, S_RUN, S_DONE
- Sub-module mp_word_adder: combinational ADDER_WIDTH-bit adder with carry in/out, instantiated once.
- FSM, shift registers and flag logic live in mp_addsub.

## Test plan
All scenarios use OPERAND_WIDTH=16, ADDER_WIDTH=4 (N_ITERATIONS=4) unless stated.
1. Add 0xFFFF + 0x0001 → oRes=0x0000, oCarry=1, oZero=1, oDone in the cycle after edge E+4.
2. Sub 0x1234 − 0x1235 → oRes=0xFFFF, oCarry=1 (borrow), oZero=0. Then sub 0x0005 − 0x0003 → oRes=0x0002, oCarry=0.
3. Cmp 0xABCD vs 0xABCD after scenario 2 → oZero=1, oCarry=0, oRes stays 0x0002. Cmp 0x0001 vs 0x0002 → oCarry=1, oZero=0.
4. Handshake:
   - iStart pulsed during RUN with different operands → ignored, result unaffected.
   - iStart held through DONE → second op accepted; oDone pulses exactly 5 cycles apart.
5. iRstn low in the 2nd RUN cycle → all outputs 0 and oReady=1 immediately, no oDone. Then add 0x0003 + 0x0004 → oRes=0x0007, oCarry=0.
6. ADDER_WIDTH=OPERAND_WIDTH=16: add 0x8000 + 0x8000 → oRes=0x0000, oCarry=1, oZero=1, oDone after edge E+1. Mode 11 with 0x0001, 0x0001 → oRes=0x0002.
